// File: rtl/rob_trace_buf_ctrl.sv
// Circular trace buffer controller for the ROB debug SRAM: arm/trigger/freeze capture plus debug read-back.
// Optional feature macro: ROB_TRACE_TIMESTAMP_EN (stores a 16-bit cycle stamp in record bits [127:112]).
`timescale 1ns/1ps
module rob_trace_buf_ctrl #(
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 128,
    parameter int POST_TRIG = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_arm,
    input  logic              trig,
    input  logic              commit_valid,
    input  logic [DATA_W-1:0] commit_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_idx,
    output logic              rd_rsp_valid,
    output logic              rd_rsp_err,
    output logic [DATA_W-1:0] rd_rsp_data,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_i,
    output logic              sram_web,
    output logic              sram_csb,
    output logic              sram_oeb,
    input  logic [DATA_W-1:0] sram_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_TRIG   = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W-1:0]   r_post_cnt;
    logic                r_rsp_valid;
    logic                r_rsp_err;

    logic                w_write;
    logic                w_ready;
    logic                w_rd_acc;
    logic                w_rd_err;
    logic                w_rd_mem;
    logic                w_rsp_ok;
    logic [ADDR_W:0]     w_sum;
    logic [ADDR_W:0]     w_wrap;
    logic [ADDR_W-1:0]   w_phys;
    logic [DATA_W-1:0]   w_rec;

`ifdef ROB_TRACE_TIMESTAMP_EN
    logic [15:0] r_ts;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)        r_ts <= '0;
        else if (cmd_arm) r_ts <= '0;
        else              r_ts <= r_ts + 16'd1;
    end

    assign w_rec = {r_ts, commit_data[DATA_W-17:0]};
`else
    assign w_rec = commit_data;
`endif

    assign w_write  = commit_valid && !cmd_arm && (r_state == S_ARMED || r_state == S_TRIG);
    assign w_ready  = !reset && !cmd_arm && !w_write;
    assign w_rd_acc = rd_req_valid && w_ready;
    assign w_rd_err = {1'b0, rd_req_idx} >= r_count;
    assign w_rd_mem = w_rd_acc && !w_rd_err;

    // Once the buffer has wrapped, the oldest record sits at the write pointer.
    assign w_sum  = {1'b0, r_wr_ptr} + {1'b0, rd_req_idx};
    assign w_wrap = w_sum - DEPTH_W;
    assign w_phys = (r_count < DEPTH_W) ? rd_req_idx :
                    (w_sum >= DEPTH_W)  ? w_wrap[ADDR_W-1:0] : w_sum[ADDR_W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (cmd_arm) begin
            w_state_nxt = S_ARMED;
        end else begin
            case (r_state)
                S_ARMED:  if (trig) w_state_nxt = (POST_TRIG == 0) ? S_FROZEN : S_TRIG;
                S_TRIG:   if (w_write && r_post_cnt == ADDR_W'(1)) w_state_nxt = S_FROZEN;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_post_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_rd_acc;
            r_rsp_err   <= w_rd_acc && w_rd_err;
            if (cmd_arm) begin
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_post_cnt <= '0;
            end else begin
                if (w_write) begin
                    r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
                    if (r_count != DEPTH_W) r_count <= r_count + 1'b1;
                end
                if (r_state == S_ARMED && trig)
                    r_post_cnt <= ADDR_W'(POST_TRIG);
                else if (r_state == S_TRIG && w_write)
                    r_post_cnt <= r_post_cnt - 1'b1;
            end
        end
    end

    assign w_rsp_ok     = r_rsp_valid && !r_rsp_err;
    assign rd_req_ready = w_ready;
    assign rd_rsp_valid = r_rsp_valid;
    assign rd_rsp_err   = r_rsp_err;
    assign rd_rsp_data  = w_rsp_ok ? sram_o : '0;
    assign state        = r_state;
    assign count        = r_count;

    assign sram_csb = !(w_write || w_rd_mem);
    assign sram_web = !w_write;
    assign sram_oeb = !w_rsp_ok;
    assign sram_a   = w_write ? r_wr_ptr : (w_rd_mem ? w_phys : '0);
    assign sram_i   = w_write ? w_rec : '0;

endmodule
